// File: rtl/pack_to_stream.sv
// pack_to_stream: decodes CoreSight TPIU formatter frames into (ID, byte) pairs.
// Optional STREAM_ID_FILTER_EN adds IdMask filtering and a saturating DropCount.
module pack_to_stream #(
  parameter logic [6:0] NULL_ID = 7'h00,
  parameter logic [6:0] MAX_ID  = 7'h6F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         PacketAvail,
  output logic         PacketNext,
  output logic         PacketNextWd,
  input  logic [15:0]  PacketOut,
  input  logic [7:0]   PacketFinal,
  output logic         StreamValid,
  input  logic         StreamReady,
  output logic [6:0]   StreamId,
  output logic [7:0]   StreamByte,
`ifdef STREAM_ID_FILTER_EN
  input  logic [127:0] IdMask,
  output logic [15:0]  DropCount,
`endif
  output logic         ProtocolErr,
  output logic         FrameDone
);

  typedef enum logic [2:0] {
    IDLE, CLAIM, REQ, CAPT, EVEN, ODD, DONE
  } state_t;

  state_t      state;
  logic [7:0]  aux;
  logic [15:0] word;
  logic [2:0]  word_idx;
  logic [6:0]  cur_id;
  logic [6:0]  pend_id;
  logic        pend_vld;

  logic [7:0]  even_b;
  logic [7:0]  odd_b;
  logic [7:0]  data_b;
  logic [6:0]  id_fld;
  logic        aux_bit;
  logic        is_id;
  logic        id_bad;
  logic        last_wd;
  logic        has_data;
  logic        id_on;
  logic        emit;
  logic        stall;

  assign even_b  = word[7:0];
  assign odd_b   = word[15:8];
  assign id_fld  = even_b[7:1];
  assign aux_bit = aux[word_idx];
  assign is_id   = even_b[0];
  assign id_bad  = id_fld > MAX_ID;
  assign last_wd = word_idx == 3'd7;
  assign stall   = StreamValid && !StreamReady;

  // even data bytes borrow their LSB from the aux byte
  assign data_b = (state == EVEN) ? {even_b[7:1], aux_bit}
                                  : odd_b;

  assign has_data = ((state == EVEN) && !is_id)
                 || ((state == ODD) && !last_wd);

`ifdef STREAM_ID_FILTER_EN
  logic masked;
  assign id_on  = IdMask[cur_id];
  assign masked = (cur_id != NULL_ID) && !id_on;
`else
  assign id_on  = 1'b1;
`endif

  assign emit = has_data && (cur_id != NULL_ID) && id_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      aux          <= '0;
      word         <= '0;
      word_idx     <= '0;
      cur_id       <= NULL_ID;
      pend_id      <= '0;
      pend_vld     <= 1'b0;
      PacketNext   <= 1'b0;
      PacketNextWd <= 1'b0;
      StreamValid  <= 1'b0;
      StreamId     <= '0;
      StreamByte   <= '0;
      ProtocolErr  <= 1'b0;
      FrameDone    <= 1'b0;
    end else begin
      PacketNext   <= 1'b0;
      PacketNextWd <= 1'b0;
      ProtocolErr  <= 1'b0;
      FrameDone    <= 1'b0;
      if (StreamValid && StreamReady)
        StreamValid <= 1'b0;
      // a byte waiting on the consumer freezes the whole decoder
      if (!stall) begin
        if (emit) begin
          StreamValid <= 1'b1;
          StreamId    <= cur_id;
          StreamByte  <= data_b;
        end
        unique case (state)
          IDLE: begin
            if (PacketAvail) begin
              PacketNext <= 1'b1;
              state      <= CLAIM;
            end
          end
          CLAIM: begin
            word_idx <= '0;
            state    <= REQ;
          end
          REQ: begin
            PacketNextWd <= 1'b1;
            state        <= CAPT;
          end
          CAPT: begin
            // strobe cycle first; the word lands the cycle after
            if (!PacketNextWd) begin
              word <= PacketOut;
              if (word_idx == 3'd0)
                aux <= PacketFinal;
              state <= EVEN;
            end
          end
          EVEN: begin
            if (is_id) begin
              if (id_bad)
                ProtocolErr <= 1'b1;
              else if (!aux_bit || last_wd)
                cur_id <= id_fld;
              else begin
                pend_id  <= id_fld;
                pend_vld <= 1'b1;
              end
            end
            state <= ODD;
          end
          ODD: begin
            if (last_wd) begin
              state <= DONE;
            end else begin
              if (pend_vld) begin
                cur_id   <= pend_id;
                pend_vld <= 1'b0;
              end
              word_idx <= word_idx + 3'd1;
              state    <= REQ;
            end
          end
          DONE: begin
            FrameDone <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STREAM_ID_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst)
      DropCount <= '0;
    else if (!stall && has_data && masked
             && DropCount != 16'hFFFF)
      DropCount <= DropCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pack_to_stream.sv
// tb_pack_to_stream: directed frames, expected pairs queued and checked
// by a decoupled monitor against what the decoder presents.
module tb_pack_to_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        PacketAvail;
  logic        PacketNext;
  logic        PacketNextWd;
  logic [15:0] PacketOut = '0;
  logic [7:0]  PacketFinal = '0;
  logic        StreamValid;
  logic        StreamReady;
  logic [6:0]  StreamId;
  logic [7:0]  StreamByte;
  logic        ProtocolErr;
  logic        FrameDone;
`ifdef STREAM_ID_FILTER_EN
  logic [127:0] id_mask = '1;
  logic [15:0]  drop_count;
`endif

  pack_to_stream dut (
    .clk          (clk),
    .rst          (rst),
    .PacketAvail  (PacketAvail),
    .PacketNext   (PacketNext),
    .PacketNextWd (PacketNextWd),
    .PacketOut    (PacketOut),
    .PacketFinal  (PacketFinal),
    .StreamValid  (StreamValid),
    .StreamReady  (StreamReady),
    .StreamId     (StreamId),
    .StreamByte   (StreamByte),
`ifdef STREAM_ID_FILTER_EN
    .IdMask       (id_mask),
    .DropCount    (drop_count),
`endif
    .ProtocolErr  (ProtocolErr),
    .FrameDone    (FrameDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] id;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frm [16];
  logic [3:0] wcnt = '0;
  int         nwd_total = 0;
  int         tests = 0;
  int         fails = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         perr_cnt = 0;
  int         stl_cnt = 0;
  int         wd_stall = 0;

  // packCollect stand-in: each strobe fetches the next frame word
  always @(posedge clk) begin
    if (PacketNext) begin
      PacketFinal <= frm[15];
      wcnt        <= '0;
    end
    if (PacketNextWd) begin
      PacketOut <= {frm[{wcnt[2:0], 1'b1}],
                    frm[{wcnt[2:0], 1'b0}]};
      wcnt      <= wcnt + 4'd1;
      nwd_total <= nwd_total + 1;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [6:0] id,
                      input logic [7:0] b);
    exp_q.push_back({id, b});
  endtask

  task automatic load_frame(input logic [127:0] v);
    for (int i = 0; i < 16; i++)
      frm[i] = v[8*i +: 8];
  endtask

  task automatic mon();
    logic       pv;
    logic [6:0] pid;
    logic [7:0] pb;
    exp_t       e;
    pv = 1'b0;
    pid = '0;
    pb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv)
          chk("stall_hold",
              {17'd0, StreamValid, StreamId, StreamByte},
              {17'd0, 1'b1, pid, pb});
        if (StreamValid && StreamReady) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL stream_extra: got id=%h byte=%h, expected none",
                     StreamId, StreamByte);
          end else begin
            e = exp_q.pop_front();
            chk("stream_pair", {17'd0, StreamId, StreamByte},
                {17'd0, e.id, e.b});
          end
          acc_cnt++;
        end
        if (StreamValid && !StreamReady) stl_cnt++;
        if (StreamValid && !StreamReady && PacketNextWd) wd_stall++;
        if (FrameDone) done_cnt++;
        if (ProtocolErr) perr_cnt++;
        pv  = StreamValid && !StreamReady;
        pid = StreamId;
        pb  = StreamByte;
      end
    end
  endtask

  task automatic claim();
    PacketAvail = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (PacketNext) begin
        PacketAvail = 1'b0;
        return;
      end
    end
    PacketAvail = 1'b0;
    tests++;
    fails++;
    $display("FAIL claim_timeout: got no PacketNext, expected one");
  endtask

  task automatic run_frame(input string nm);
    int  w0;
    int  d0;
    logic ok;
    w0 = nwd_total;
    d0 = done_cnt;
    ok = 1'b0;
    claim();
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (FrameDone) ok = 1'b1;
    end
    chk({nm, "_done_seen"}, {31'd0, ok}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_strobes"}, nwd_total - w0, 32'd8);
    chk({nm, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({nm, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"},
        {12'd0, PacketNext, PacketNextWd, StreamValid,
         StreamId, StreamByte, ProtocolErr, FrameDone},
        32'd0);
  endtask

  int a0;
  int p0;
  int s0;
  int w0;

  initial begin
    rst = 1'b1;
    PacketAvail = 1'b0;
    StreamReady = 1'b1;
    for (int i = 0; i < 16; i++) frm[i] = '0;
    fork
      mon();
    join_none
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // all data under NULL_ID; last even byte sets ID 3 despite aux bit 7
    a0 = acc_cnt;
    load_frame(128'hE8_07_16_0C_15_0A_14_08_13_06_12_04_11_02_10_00);
    run_frame("null_frame");
    chk("null_frame_bytes", acc_cnt - a0, 32'd0);

    // leading ID 3, fourteen data bytes
    frm[0] = 8'h07;
    for (int k = 1; k < 15; k++) begin
      frm[k] = 8'h10 + 8'(2 * k);
      push(7'h03, 8'h10 + 8'(2 * k));
    end
    frm[15] = 8'h00;
    run_frame("id3_frame");

    frm[0] = 8'h05;
    for (int k = 1; k < 15; k++) begin
      frm[k] = 8'h80 + 8'(2 * k);
      push(7'h02, 8'h80 + 8'(2 * k));
    end
    frm[15] = 8'h00;
    run_frame("id2_frame");

    // delayed ID change plus aux LSBs, with a 5-cycle consumer stall
    load_frame(128'hA5_5C_4D_5A_4B_58_49_56_47_54_45_52_43_50_41_07);
    push(7'h02, 8'h41); push(7'h03, 8'h50);
    push(7'h03, 8'h43); push(7'h03, 8'h53);
    push(7'h03, 8'h45); push(7'h03, 8'h54);
    push(7'h03, 8'h47); push(7'h03, 8'h56);
    push(7'h03, 8'h49); push(7'h03, 8'h59);
    push(7'h03, 8'h4B); push(7'h03, 8'h5A);
    push(7'h03, 8'h4D); push(7'h03, 8'h5D);
    a0 = acc_cnt;
    s0 = stl_cnt;
    fork
      run_frame("delayed_id");
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk);
          #1;
          if (acc_cnt >= a0 + 4) break;
        end
        StreamReady = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        StreamReady = 1'b1;
      end
    join
    chk("stall_cycles", stl_cnt - s0, 32'd5);
    chk("stall_no_strobe", wd_stall, 32'd0);

    // reserved IDs 7D and 70 rejected, 05 and 6F accepted
    p0 = perr_cnt;
    load_frame(128'h01_EE_DD_DF_BB_AA_99_E1_77_66_55_0B_33_22_11_FB);
    push(7'h03, 8'h11); push(7'h03, 8'h22);
    push(7'h03, 8'h33); push(7'h05, 8'h55);
    push(7'h05, 8'h66); push(7'h05, 8'h77);
    push(7'h05, 8'h99); push(7'h05, 8'hAA);
    push(7'h05, 8'hBB); push(7'h6F, 8'hDD);
    push(7'h6F, 8'hEE);
    run_frame("reserved_id");
    chk("protocol_err_pulses", perr_cnt - p0, 32'd2);

    // abandon a frame with rst after the third word strobe
    frm[0] = 8'h0D;
    for (int k = 1; k < 15; k++) frm[k] = 8'h30 + 8'(k);
    frm[15] = 8'h00;
    push(7'h06, 8'h31); push(7'h06, 8'h32); push(7'h06, 8'h33);
    w0 = nwd_total;
    claim();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (nwd_total - w0 >= 3) break;
    end
    chk("pre_reset_strobes", nwd_total - w0, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("mid_reset");
    rst = 1'b0;
    chk("mid_reset_queue", exp_q.size(), 32'd0);

    // leading data must be dropped: curId is NULL again after rst
    frm[0] = 8'h40;
    frm[1] = 8'h41;
    frm[2] = 8'h09;
    for (int k = 3; k < 15; k++) begin
      frm[k] = 8'h40 + 8'(k);
      push(7'h04, 8'h40 + 8'(k));
    end
    frm[15] = 8'h00;
    run_frame("post_reset");

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
